// File: rtl/cache_arbiter_if.sv
// Bundle between the two cache miss paths, the arbiter and the shared memory port.
// master is the arbiter's view (it owns the memory port); slave is the caches/memory side.
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Serializes I-cache and D-cache line transactions onto one memory port,
// alternating ownership under contention so neither miss path starves.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    state_t            state;
    logic              last_gnt_d;
    logic              op_write;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              i_req;
    logic              d_req;
    logic              d_first;
    logic [ADDR_W-1:0] addr_sel;
    logic [LINE_W-1:0] wdata_sel;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;
    // A tie goes to whichever side did not own the previous transaction.
    assign d_first = d_req && (!i_req || !last_gnt_d);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            last_gnt_d  <= 1'b0;
            op_write    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_first) begin
                        state       <= SERVE_D;
                        last_gnt_d  <= 1'b1;
                        op_write    <= bus.d_write;
                        mem_read_q  <= !bus.d_write;
                        mem_write_q <= bus.d_write;
                    end else if (i_req) begin
                        state       <= SERVE_I;
                        last_gnt_d  <= 1'b0;
                        op_write    <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.mem_resp) begin
                        state       <= DONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end
                end
                // One quiet cycle lets the finished requester drop its held request.
                DONE: begin
                    state    <= IDLE;
                    op_write <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        case (state)
            SERVE_I: addr_sel = bus.i_addr;
            SERVE_D: begin
                addr_sel = bus.d_addr;
                if (op_write) wdata_sel = bus.d_wdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.i_resp    = (state == SERVE_I) && bus.mem_resp;
    assign bus.d_resp    = (state == SERVE_D) && bus.mem_resp;

    a_i_held:    assert property (@(posedge clk) disable iff (!rst) (state == SERVE_I) |-> bus.i_read);
    a_d_held:    assert property (@(posedge clk) disable iff (!rst) (state == SERVE_D) |-> (bus.d_read || bus.d_write));
    a_op_excl:   assert property (@(posedge clk) disable iff (!rst) !(mem_read_q && mem_write_q));
    a_resp_excl: assert property (@(posedge clk) disable iff (!rst) !(bus.i_resp && bus.d_resp));
endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter: a driver issues request rounds and queues the expected
// memory transactions, a memory responder answers them, and a monitor scores the DUT.
module tb_cache_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef logic [LINE_W-1:0] line_t;
    typedef struct {
        bit                is_d;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        line_t             wdata;
        int                t_issue;
    } exp_t;

    logic  clk;
    logic  rst;
    exp_t  sbq[$];
    int    cyc = 0;
    logic  rst_q = 1'b1;
    int    n_chk = 0;
    int    n_fail = 0;
    bit    model_last_d;
    bit    force_resp;
    int    fixed_lat;
    bit    end_req;

    cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    function automatic line_t rand_line();
        line_t v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input line_t got, input line_t want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    // Reference rule: the grant order follows "tie goes to the side not granted last".
    task automatic push_exp(input bit is_d, input bit wr, input logic [ADDR_W-1:0] a,
                            input line_t w, input int t);
        exp_t e;
        e.is_d    = is_d;
        e.wr      = wr;
        e.addr    = a;
        e.wdata   = wr ? w : '0;
        e.t_issue = t;
        sbq.push_back(e);
        model_last_d = is_d;
    endtask

    task automatic run_round(input bit wi, input bit wd, input bit dr, input bit dw,
                             input bit ei, input bit ed, input logic [ADDR_W-1:0] ia,
                             input logic [ADDR_W-1:0] da, input line_t w);
        int t;
        int i_left;
        int d_left;
        bit i_pend;
        bit d_pend;
        bit gi;
        bit gd;
        @(posedge clk);
        #1;
        bus.i_read  = wi;
        bus.i_addr  = ia;
        bus.d_read  = wd & dr;
        bus.d_write = wd & dw;
        bus.d_addr  = da;
        bus.d_wdata = w;
        t = cyc;
        if (wi && wd && !model_last_d) begin
            push_exp(1'b1, dw, da, w, t);
            push_exp(1'b0, 1'b0, ia, '0, t);
        end else if (wi && wd) begin
            push_exp(1'b0, 1'b0, ia, '0, t);
            push_exp(1'b1, dw, da, w, t);
        end else if (wd) begin
            push_exp(1'b1, dw, da, w, t);
        end else if (wi) begin
            push_exp(1'b0, 1'b0, ia, '0, t);
        end
        i_pend = wi;
        d_pend = wd;
        i_left = -1;
        d_left = -1;
        for (int k = 0; k < 300 && (i_pend || d_pend); k++) begin
            @(negedge clk);
            gi = bus.i_resp;
            gd = bus.d_resp;
            if (i_pend && i_left < 0 && gi) i_left = ei ? 1 : 0;
            if (d_pend && d_left < 0 && gd) d_left = ed ? 1 : 0;
            @(posedge clk);
            #1;
            if (i_left == 0) begin
                bus.i_read = 1'b0;
                i_pend = 1'b0;
                i_left = -1;
            end else if (i_left > 0) begin
                i_left--;
            end
            if (d_left == 0) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
                d_pend = 1'b0;
                d_left = -1;
            end else if (d_left > 0) begin
                d_left--;
            end
        end
        if (i_pend || d_pend) begin
            $display("FAIL round_timeout at cycle %0d: got pending i=%0d d=%0d, want none", cyc, i_pend, d_pend);
            $fatal(1, "round timeout");
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        model_last_d = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic mid_op_reset();
        bit seen;
        line_t w;
        fixed_lat = 6;
        w = rand_line();
        @(posedge clk);
        #1;
        bus.d_write = 1'b1;
        bus.d_read  = 1'b0;
        bus.d_addr  = 32'h4000;
        bus.d_wdata = w;
        push_exp(1'b1, 1'b1, 32'h4000, w, cyc);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.mem_write;
        end
        if (!seen) begin
            $display("FAIL mid_op_grant at cycle %0d: got no mem_write, want one", cyc);
            $fatal(1, "no grant");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.d_write = 1'b0;
        model_last_d = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 fixed_lat = 0;
    endtask

    // Driver
    initial begin
        rst          = 1'b0;
        force_resp   = 1'b1;
        fixed_lat    = 0;
        end_req      = 1'b0;
        model_last_d = 1'b0;
        bus.i_read   = 1'b1;
        bus.i_addr   = 32'h60;
        bus.d_read   = 1'b0;
        bus.d_write  = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b1;
        force_resp = 1'b0;
        bus.i_read = 1'b0;
        repeat (2) @(posedge clk);

        run_round(1, 0, 0, 0, 0, 0, 32'h60, 32'h0, '0);
        run_round(0, 1, 0, 1, 0, 0, 32'h0, 32'h1000, {32{8'hA5}});
        apply_reset();
        run_round(1, 1, 1, 0, 0, 0, 32'h200, 32'h300, rand_line());
        run_round(1, 1, 1, 0, 0, 0, 32'h220, 32'h320, rand_line());
        run_round(1, 0, 0, 0, 1, 0, 32'h240, 32'h0, '0);
        run_round(1, 1, 1, 1, 1, 1, 32'h260, 32'h360, rand_line());
        mid_op_reset();

        for (int r = 0; r < 40; r++) begin
            bit wi;
            bit wd;
            bit ei;
            bit ed;
            int dop;
            logic [ADDR_W-1:0] ia;
            logic [ADDR_W-1:0] da;
            wi  = 1'($urandom_range(0, 1));
            wd  = 1'($urandom_range(0, 1));
            if (!wi && !wd) wd = 1'b1;
            ei  = 1'($urandom_range(0, 1));
            ed  = 1'($urandom_range(0, 1));
            dop = $urandom_range(1, 3);
            ia  = $urandom & 32'hFFFF_FFE0;
            da  = $urandom & 32'hFFFF_FFE0;
            run_round(wi, wd, dop[0], dop[1], ei, ed, ia, da, rand_line());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (5) @(posedge clk);
        #1 end_req = 1'b1;
    end

    // Memory responder: answers each new op after a short latency; keeps counting through a reset.
    initial begin
        int cnt;
        bit active;
        bit resp_last;
        cnt = 0;
        resp_last = 1'b0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            active = bus.mem_read | bus.mem_write;
            @(posedge clk);
            #2;
            bus.mem_resp = force_resp;
            if (cnt == 1) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = rand_line();
                cnt = 0;
            end else if (cnt > 1) begin
                cnt--;
            end else if (active && !resp_last) begin
                cnt = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
            end
            resp_last = bus.mem_resp;
        end
    end

    // Monitor / scoreboard
    initial begin
        bit   started;
        bit   cur_valid;
        bit   after_resp;
        bit   resp_now;
        exp_t cur;
        int   last_resp;
        int   want_start;
        started    = 1'b0;
        cur_valid  = 1'b0;
        after_resp = 1'b0;
        last_resp  = -100;
        forever begin
            @(negedge clk);
            if (end_req) begin
                chk("sb_drained", line_t'(sbq.size()), '0);
                chk("idle_at_end", line_t'({bus.mem_read, bus.mem_write}), '0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
            if (rst_q == 1'b0) started = 1'b1;
            resp_now = 1'b0;
            if (started && rst_q == 1'b0) begin
                chk("reset_outputs", line_t'({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp,
                                              |bus.mem_addr, |bus.mem_wdata}), '0);
                chk("reset_i_rdata", bus.i_rdata, bus.mem_rdata);
                chk("reset_d_rdata", bus.d_rdata, bus.mem_rdata);
                cur_valid = 1'b0;
                last_resp = -100;
            end else if (started) begin
                chk("op_exclusive", line_t'(bus.mem_read & bus.mem_write), '0);
                chk("resp_exclusive", line_t'(bus.i_resp & bus.d_resp), '0);
                if (!bus.mem_write) chk("wdata_zero", bus.mem_wdata, '0);
                if (after_resp) begin
                    chk("done_gap", line_t'({bus.mem_read, bus.mem_write}), '0);
                end else if ((bus.mem_read || bus.mem_write) && !cur_valid) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_grant", line_t'({bus.mem_read, bus.mem_write}), '0);
                    end else begin
                        cur = sbq.pop_front();
                        want_start = (cur.t_issue + 1 > last_resp + 3) ? cur.t_issue + 1 : last_resp + 3;
                        chk("grant_cycle", line_t'(cyc), line_t'(want_start));
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) begin
                    chk("mem_op", line_t'({bus.mem_read, bus.mem_write}), line_t'({!cur.wr, cur.wr}));
                    chk("mem_addr", line_t'(bus.mem_addr), line_t'(cur.addr));
                    if (cur.wr) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                    if (bus.mem_resp) begin
                        chk("resp_side", line_t'({bus.i_resp, bus.d_resp}), line_t'({!cur.is_d, cur.is_d}));
                        chk("rdata", cur.is_d ? bus.d_rdata : bus.i_rdata, bus.mem_rdata);
                        cur_valid = 1'b0;
                        last_resp = cyc;
                        resp_now  = 1'b1;
                    end else begin
                        chk("early_resp", line_t'({bus.i_resp, bus.d_resp}), '0);
                    end
                end else begin
                    chk("stray_resp", line_t'({bus.i_resp, bus.d_resp}), '0);
                end
            end
            after_resp = resp_now;
        end
    end
endmodule
